// File: rtl/regbank_pkg.sv
// Shared types and address decode helper for the dual-host register bank.
package regbank_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   typedef enum logic {HOST_A, HOST_B} host_t;

   typedef enum logic [1:0] {CFG, STATUS, OOR} addr_class_t;

   // Classify a host address: config window first, status window next, rest out of range.
   function automatic addr_class_t addr_class(input logic [31:0] addr,
                                              input int unsigned num_cfg,
                                              input int unsigned num_status);
      addr_class_t cls;
      if (addr < num_cfg) begin
         cls = CFG;
      end else if (addr < num_cfg + num_status) begin
         cls = STATUS;
      end else begin
         cls = OOR;
      end
      return cls;
   endfunction

endpackage

// File: rtl/regbank_rr_arbiter.sv
// Two-host round-robin arbiter. Issues a one-hot grant (bit 0 = host A, bit 1 = host B)
// only while ena is high; on a tie the host that did not win last time is granted.
module regbank_rr_arbiter
   import regbank_pkg::*;
(
   input  logic       clk,
   input  logic       rstb,
   input  logic       ena,
   input  logic       a_req,
   input  logic       b_req,
   output logic [1:0] grant
);

   host_t last_grant_q;

   // Grant selection: single requester wins outright, ties go away from last_grant.
   always_comb begin
      grant = 2'b00;
      if (ena) begin
         if (a_req && b_req) begin
            grant = (last_grant_q == HOST_B) ? 2'b01 : 2'b10;
         end else if (a_req) begin
            grant = 2'b01;
         end else if (b_req) begin
            grant = 2'b10;
         end
      end
   end

   // Remember the most recent winner; reset to B so A wins the first tie.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         last_grant_q <= HOST_B;
      end else if (grant[0]) begin
         last_grant_q <= HOST_A;
      end else if (grant[1]) begin
         last_grant_q <= HOST_B;
      end
   end

endmodule

// File: rtl/dual_host_regbank.sv
// Dual-host register bank: config (R/W) and status (RO) registers shared by host A and
// host B through a round-robin arbiter and a three-state IDLE/ACCESS/ACK sequencer.
// Optional build macro REGBANK_STICKY_STATUS_EN turns status bits into sticky flops that
// are cleared by a read (set wins over clear); without it status reads sample live inputs.
module dual_host_regbank
   import regbank_pkg::*;
#(
   parameter int unsigned                    NUM_CFG     = 8,
   parameter int unsigned                    NUM_STATUS  = 8,
   parameter int unsigned                    REG_WIDTH   = 8,
   // 2**ADDR_W must cover NUM_CFG+NUM_STATUS, otherwise decode aliases.
   parameter int unsigned                    ADDR_W      = 8,
   parameter logic [NUM_CFG*REG_WIDTH-1:0]   CFG_RST_VAL = '0
) (
   input  logic                              clk,
   input  logic                              rstb,
   input  logic                              ena,
   input  logic                              a_req,
   input  logic                              a_wr_rdn,
   input  logic [ADDR_W-1:0]                 a_addr,
   input  logic [REG_WIDTH-1:0]              a_wdata,
   output logic                              a_ack,
   output logic [REG_WIDTH-1:0]              a_rdata,
   output logic                              a_err,
   input  logic                              b_req,
   input  logic                              b_wr_rdn,
   input  logic [ADDR_W-1:0]                 b_addr,
   input  logic [REG_WIDTH-1:0]              b_wdata,
   output logic                              b_ack,
   output logic [REG_WIDTH-1:0]              b_rdata,
   output logic                              b_err,
   output logic [NUM_CFG*REG_WIDTH-1:0]      config_regs,
   input  logic [NUM_STATUS*REG_WIDTH-1:0]   status_regs
);

   localparam int unsigned CfgBits  = NUM_CFG * REG_WIDTH;
   localparam int unsigned StatBits = NUM_STATUS * REG_WIDTH;

   state_t                 state_q, state_d;
   host_t                  host_q, host_d;
   logic                   wr_q, wr_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
   logic [CfgBits-1:0]     cfg_q, cfg_d;
   logic                   a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic                   a_err_q, a_err_d, b_err_q, b_err_d;
   logic [REG_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic [1:0]             grant;
   logic                   arb_ena;
   addr_class_t            cls;
   logic [REG_WIDTH-1:0]   rd_val;
   logic [StatBits-1:0]    status_view;

   // New grants are only possible from IDLE, and only while the block is enabled.
   assign arb_ena = ena && (state_q == IDLE);

   regbank_rr_arbiter u_arbiter (
      .clk   (clk),
      .rstb  (rstb),
      .ena   (arb_ena),
      .a_req (a_req),
      .b_req (b_req),
      .grant (grant)
   );

   assign cls = addr_class(32'(addr_q), NUM_CFG, NUM_STATUS);

`ifdef REGBANK_STICKY_STATUS_EN
   logic [StatBits-1:0] sticky_q, sticky_d;

   // Accumulate status bits; a status read clears its register but a live 1 still sets.
   always_comb begin
      sticky_d = sticky_q | status_regs;
      if (state_q == ACCESS && !wr_q && cls == STATUS) begin
         for (int i = 0; i < NUM_STATUS; i++) begin
            if (addr_q == ADDR_W'(NUM_CFG + i)) begin
               sticky_d[i*REG_WIDTH +: REG_WIDTH] = status_regs[i*REG_WIDTH +: REG_WIDTH];
            end
         end
      end
   end

   // Sticky status storage.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign status_view = sticky_q;
`else
   assign status_view = status_regs;
`endif

   // Read mux over the latched address; out-of-range addresses fall through to zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            rd_val = cfg_q[i*REG_WIDTH +: REG_WIDTH];
         end
      end
      for (int i = 0; i < NUM_STATUS; i++) begin
         if (addr_q == ADDR_W'(NUM_CFG + i)) begin
            rd_val = status_view[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   // Sequencer next state plus request latching, write commit and response loading.
   always_comb begin
      state_d   = state_q;
      host_d    = host_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cfg_d     = cfg_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_err_d   = a_err_q;
      b_err_d   = b_err_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               host_d  = grant[1] ? HOST_B : HOST_A;
               wr_d    = grant[1] ? b_wr_rdn : a_wr_rdn;
               addr_d  = grant[1] ? b_addr : a_addr;
               wdata_d = grant[1] ? b_wdata : a_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = ACK;
            if (wr_q && cls == CFG) begin
               for (int i = 0; i < NUM_CFG; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                     cfg_d[i*REG_WIDTH +: REG_WIDTH] = wdata_q;
                  end
               end
            end
            // Only the granted host's response registers move.
            if (host_q == HOST_A) begin
               a_ack_d = 1'b1;
               a_err_d = (cls == OOR);
               if (!wr_q) begin
                  a_rdata_d = rd_val;
               end
            end else begin
               b_ack_d = 1'b1;
               b_err_d = (cls == OOR);
               if (!wr_q) begin
                  b_rdata_d = rd_val;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched request fields, config storage and host response registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= IDLE;
         host_q    <= HOST_A;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cfg_q     <= CFG_RST_VAL;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         host_q    <= host_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cfg_q     <= cfg_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
   assign a_err       = a_err_q;
   assign b_err       = b_err_q;
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign config_regs = cfg_q;

endmodule

// File: tb/tb_dual_host_regbank.sv
// Directed bench for dual_host_regbank: table of single-host transactions plus hand-written
// sequences for arbitration ties, ena gating, mid-transaction reset and status reads.
module tb_dual_host_regbank;

   localparam logic [63:0] CFG_RST  = 64'h0000_0000_0000_A500;
   localparam logic [63:0] STAT_VAL = 64'h0000_0000_0000_6600;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        ena = 1'b1;
   logic        a_req = 1'b0, a_wr_rdn = 1'b0;
   logic [7:0]  a_addr = '0, a_wdata = '0;
   logic        a_ack, a_err;
   logic [7:0]  a_rdata;
   logic        b_req = 1'b0, b_wr_rdn = 1'b0;
   logic [7:0]  b_addr = '0, b_wdata = '0;
   logic        b_ack, b_err;
   logic [7:0]  b_rdata;
   logic [63:0] config_regs;
   logic [63:0] status_regs = STAT_VAL;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dual_host_regbank #(
      .NUM_CFG     (8),
      .NUM_STATUS  (8),
      .REG_WIDTH   (8),
      .ADDR_W      (8),
      .CFG_RST_VAL (CFG_RST)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .ena         (ena),
      .a_req       (a_req),
      .a_wr_rdn    (a_wr_rdn),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_ack       (a_ack),
      .a_rdata     (a_rdata),
      .a_err       (a_err),
      .b_req       (b_req),
      .b_wr_rdn    (b_wr_rdn),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_ack       (b_ack),
      .b_rdata     (b_rdata),
      .b_err       (b_err),
      .config_regs (config_regs),
      .status_regs (status_regs)
   );

   typedef struct {
      bit         host_b;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      bit         chk_rd;
      logic [7:0] exp_rdata;
      bit         exp_err;
   } vec_t;

   vec_t vecs[11];

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // One transaction on one host; checks 2-cycle latency, one-cycle ack, response, isolation.
   task automatic run_txn(input vec_t v, input string tag);
      int         lat;
      bit         got, other;
      logic [7:0] rd;
      logic       er;
      @(posedge clk); #1;
      if (v.host_b) begin
         b_req = 1'b1; b_wr_rdn = v.wr; b_addr = v.addr; b_wdata = v.wdata;
      end else begin
         a_req = 1'b1; a_wr_rdn = v.wr; a_addr = v.addr; a_wdata = v.wdata;
      end
      lat = 0; got = 0; other = 0; rd = '0; er = 1'b0;
      while (!got && lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (v.host_b ? a_ack : b_ack) other = 1;
         if (v.host_b ? b_ack : a_ack) begin
            got = 1;
            rd  = v.host_b ? b_rdata : a_rdata;
            er  = v.host_b ? b_err : a_err;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'd2);
      check({tag, " err"}, 64'(er), 64'(v.exp_err));
      if (v.chk_rd) check({tag, " rdata"}, 64'(rd), 64'(v.exp_rdata));
      @(posedge clk); #1;
      if (v.host_b ? a_ack : b_ack) other = 1;
      check({tag, " ack one cycle"}, 64'(v.host_b ? b_ack : a_ack), 64'd0);
      check({tag, " other ack quiet"}, 64'(other), 64'd0);
   endtask

   initial begin
      int   order[8];
      int   n_ord, cyc;
      bit   seen;
      vec_t v;

      //             host_b wr addr   wdata  chk  exp    err
      vecs[0]  = '{0, 1, 8'd3,   8'h5C, 0, 8'h00, 0};
      vecs[1]  = '{0, 0, 8'd3,   8'h00, 1, 8'h5C, 0};
      vecs[2]  = '{0, 0, 8'd1,   8'h00, 1, 8'hA5, 0};
      vecs[3]  = '{1, 1, 8'd7,   8'h3C, 0, 8'h00, 0};
      vecs[4]  = '{1, 0, 8'd7,   8'h00, 1, 8'h3C, 0};
      vecs[5]  = '{1, 0, 8'd16,  8'h00, 1, 8'h00, 1};
      vecs[6]  = '{1, 1, 8'd9,   8'hFF, 0, 8'h00, 0};
      vecs[7]  = '{1, 0, 8'd9,   8'h00, 1, 8'h66, 0};
      vecs[8]  = '{0, 1, 8'd200, 8'h11, 0, 8'h00, 1};
      vecs[9]  = '{0, 0, 8'd0,   8'h00, 1, 8'h00, 0};
      vecs[10] = '{0, 0, 8'd8,   8'h00, 1, 8'h00, 0};

      // Reset state.
      @(posedge clk); #1;
      check("reset config_regs", config_regs, CFG_RST);
      check("reset cfg slice1", 64'(config_regs[15:8]), 64'hA5);
      check("reset acks", {62'd0, a_ack, b_ack}, 64'd0);
      check("reset errs", {62'd0, a_err, b_err}, 64'd0);
      check("reset rdata", {48'd0, a_rdata, b_rdata}, 64'd0);
      rstb = 1'b1;

      // Table of single-host transactions.
      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
         if (i == 0) check("cfg slice3 after write", 64'(config_regs[31:24]), 64'h5C);
      end
      check("config after table", config_regs, 64'h3C00_0000_5C00_A500);
      check("b_rdata held across A txns", 64'(b_rdata), 64'h66);

      // Arbitration: B goes last so A must win the following ties; expect A,B,A,B.
      v = '{1, 0, 8'd7, 8'h00, 1, 8'h3C, 0};
      run_txn(v, "pre-arb B");
      n_ord = 0;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         a_req = 1'b1; a_wr_rdn = 1'b0; a_addr = 8'd3;
         b_req = 1'b1; b_wr_rdn = 1'b0; b_addr = 8'd7;
         cyc = 0;
         while ((a_req || b_req) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack) begin
               if (n_ord < 8) order[n_ord] = 0;
               n_ord++;
               a_req = 1'b0;
               check("arb a_rdata", 64'(a_rdata), 64'h5C);
            end
            if (b_ack) begin
               if (n_ord < 8) order[n_ord] = 1;
               n_ord++;
               b_req = 1'b0;
               check("arb b_rdata", 64'(b_rdata), 64'h3C);
            end
         end
         check("arb round done in time", 64'(a_req || b_req), 64'd0);
         a_req = 1'b0;
         b_req = 1'b0;
      end
      @(posedge clk); #1;
      check("arb acks drop", {62'd0, a_ack, b_ack}, 64'd0);
      check("arb grant count", 64'(n_ord), 64'd4);
      if (n_ord == 4) begin
         check("arb order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 64'b0101);
      end

      // ena low blocks grants; raising it lets the pending request through.
      @(posedge clk); #1;
      ena = 1'b0;
      a_req = 1'b1; a_wr_rdn = 1'b0; a_addr = 8'd3;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (a_ack) seen = 1;
      end
      check("ena low no ack", 64'(seen), 64'd0);
      ena = 1'b1;
      cyc = 0;
      while (!a_ack && cyc < 6) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("ena high ack", 64'(a_ack), 64'd1);
      check("ena high rdata", 64'(a_rdata), 64'h5C);
      a_req = 1'b0;
      @(posedge clk); #1;

      // Reset during ACCESS of a write: no ack, write lost, config back to reset value.
      @(posedge clk); #1;
      a_req = 1'b1; a_wr_rdn = 1'b1; a_addr = 8'd0; a_wdata = 8'hFF;
      @(posedge clk); #1;
      rstb = 1'b0;
      a_req = 1'b0;
      #1;
      check("midrst config", config_regs, CFG_RST);
      check("midrst ack", 64'(a_ack), 64'd0);
      #2;
      rstb = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (a_ack) seen = 1;
      end
      check("midrst no late ack", 64'(seen), 64'd0);
      check("midrst slice0", 64'(config_regs[7:0]), 64'h00);
      v = '{0, 0, 8'd1, 8'h00, 1, 8'hA5, 0};
      run_txn(v, "post-reset read");

      // One-cycle pulse on status reg0 bit 2, then two reads of that status register.
      @(posedge clk); #1;
      status_regs = STAT_VAL | 64'h04;
      @(posedge clk); #1;
      status_regs = STAT_VAL;
`ifdef REGBANK_STICKY_STATUS_EN
      v = '{0, 0, 8'd8, 8'h00, 1, 8'h04, 0};
`else
      v = '{0, 0, 8'd8, 8'h00, 1, 8'h00, 0};
`endif
      run_txn(v, "status read 1");
      v = '{0, 0, 8'd8, 8'h00, 1, 8'h00, 0};
      run_txn(v, "status read 2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dual_host_regbank.md
Name: dual_host_regbank

Overview:
- Shared register bank serving two independent host ports: host A (SPI peripheral) and host B (I2C peripheral).
- Round-robin arbitration with a req/ack handshake per host.
- Config and status counts are independent; no requirement that NUM_CFG equals NUM_STATUS.
- Sits between the serial peripherals and the core: drives the flat config_regs vector and samples the flat status_regs vector.

Parameters:
- NUM_CFG, 8, number of read/write config registers.
- NUM_STATUS, 8, number of read-only status registers.
- REG_WIDTH, 8, bits per register.
- ADDR_W, 8, host address width; must satisfy 2**ADDR_W >= NUM_CFG+NUM_STATUS.
- CFG_RST_VAL, '0, NUM_CFG*REG_WIDTH vector of per-register reset values (register i at slice i).

Ports:
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- ena  in  1  block enable; gates new grants only
- a_req  in  1  host A request, level, held until a_ack
- a_wr_rdn  in  1  host A 1=write 0=read
- a_addr  in  ADDR_W  host A register address
- a_wdata  in  REG_WIDTH  host A write data
- a_ack  out  1  host A completion pulse
- a_rdata  out  REG_WIDTH  host A read data, valid with a_ack
- a_err  out  1  host A out-of-range flag, valid with a_ack
- b_req, b_wr_rdn, b_addr, b_wdata, b_ack, b_rdata, b_err: same as host A, for host B
- config_regs  out  NUM_CFG*REG_WIDTH  flat config vector, register i at [(i+1)*REG_WIDTH-1 : i*REG_WIDTH]
- status_regs  in  NUM_STATUS*REG_WIDTH  flat status vector, same packing

Behaviour:
- Address map:
  - 0..NUM_CFG-1: config registers.
  - NUM_CFG..NUM_CFG+NUM_STATUS-1: status registers.
  - Anything above: out of range.
- Reset values:
  - config registers = CFG_RST_VAL.
  - a_ack, b_ack, a_err, b_err = 0.
  - a_rdata, b_rdata = 0.
  - FSM = IDLE.
  - last_grant = B, so host A wins the first tie.
- FSM states:
  - IDLE: if ena and any req is high, latch the winner and its wr_rdn/addr/wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: perform the access.
    - Write to a config register: committed on the edge leaving ACCESS.
    - Read: the winner's rdata register is loaded on that edge.
    - Next state is ACK.
  - ACK: the winner's ack = 1 for exactly one cycle, with rdata and err stable. Next state is IDLE and ack returns to 0.
- Latency and throughput:
  - req sampled at edge 0; ack high between edges 1 and 2.
  - Maximum throughput: one transaction per 3 cycles.
- Host handshake:
  - The host must deassert req on the edge that samples ack = 1.
  - A req still high in IDLE is a new transaction.
- Arbitration:
  - One host requesting: that host is granted.
  - Both requesting in IDLE: the host other than last_grant is granted.
  - last_grant updates on every grant.
  - The losing req stays pending and is served in the next IDLE. No starvation.
- Out-of-range access:
  - Writes are ignored.
  - Reads return 0.
  - err = 1 with ack.
- Write to a status address: ignored, err = 0, ack given.
- Read data and ack go only to the granted host; the other host's ack/rdata/err stay unchanged (rdata holds its last value).
- ena low:
  - No new grant from IDLE.
  - A transaction in ACCESS or ACK completes normally.
  - Config registers hold.
- Changes to addr/wdata during ACCESS or ACK have no effect, because the fields were latched at grant.
- rstb asserted mid-transaction:
  - Immediate return to reset values.
  - No ack is issued.
  - A write that has not yet committed is lost.
- config_regs is a registered output, updated on the commit edge.
- Status path without the macro: live sample of status_regs taken on the ACCESS edge.

Optional Feature:
- Macro: REGBANK_STICKY_STATUS_EN.
- Defined:
  - Each status bit is a sticky flop, set on any cycle its status_regs bit is 1, reset to 0.
  - A read of a status register returns the sticky value and clears that register on the same commit edge.
  - If an input bit is 1 on the clearing edge, that bit stays set (set wins).
- Undefined: status reads return the live sampled value and there is no storage.

Decomposition:
- Package regbank_pkg:
  - state_t enum {IDLE, ACCESS, ACK}.
  - host_t enum {HOST_A, HOST_B}.
  - Address-class helper function returning CFG, STATUS or OOR.
- Sub-module regbank_rr_arbiter: two reqs, ena, last_grant state, one-hot grant output.
- Register storage, FSM and muxing stay in the top module.

Test Plan:
- Reset with CFG_RST_VAL = 0x..._A5_00 → config_regs slice1 = 0xA5, slice0 = 0x00; a_ack = b_ack = 0; rdata = 0.
- A writes addr 3 = 0x5C, then reads addr 3 → a_ack 2 cycles after req; a_rdata = 0x5C; config_regs slice3 = 0x5C; b_ack stays 0.
- A and B assert req in the same cycle repeatedly, for 4 transactions → grant order A, B, A, B; each ack one cycle; no lost request.
- B reads addr NUM_CFG+NUM_STATUS (out of range) → b_rdata = 0, b_err = 1. B writes a status address → ignored, b_err = 0.
- rstb pulsed during ACCESS of an A write of 0xFF to addr 0 → no a_ack; config_regs returns to CFG_RST_VAL; next transaction works.
- With REGBANK_STICKY_STATUS_EN: pulse status bit 2 of reg 0 for one cycle, then read addr NUM_CFG twice → first read 0x04, second 0x00. Without the macro, the same stimulus reads 0x00 both times.
